// File: rtl/period_meter.sv
// Measures the period and high time of a slow, asynchronous input in clk cycles.
// One result per two consecutive rising edges, held with a valid/ready handshake.

// state   | meaning
// IDLE    | disabled, waiting for meas_en
// ARM     | waiting for the first rising edge of sig_in
// MEASURE | counting clk cycles until the next rising edge or saturation
// HOLD    | result presented on valid, waiting for ready
module period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  input  logic             ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             sig_m, sig_s, sig_d;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             timeout_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_m <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_m <= sig_in;
      sig_s <= sig_m;
      sig_d <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_cnt    <= hi_cnt_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_cnt_nxt    = hi_cnt;
    period_nxt    = period;
    high_time_nxt = high_time;
    timeout_nxt   = timeout;
    case (state)
      IDLE: begin
        if (meas_en) state_nxt = ARM;
      end
      ARM: begin
        if (!meas_en) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt  = MEASURE;
          cnt_nxt    = CNT_ONE;
          hi_cnt_nxt = CNT_ONE;
        end
      end
      MEASURE: begin
        // a rise on the saturating cycle still counts as a real edge
        if (!meas_en) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt     = HOLD;
          period_nxt    = cnt;
          high_time_nxt = hi_cnt;
          timeout_nxt   = 1'b0;
        end else if (cnt == CNT_MAX) begin
          state_nxt     = HOLD;
          period_nxt    = CNT_MAX;
          high_time_nxt = hi_cnt;
          timeout_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          if (sig_s) hi_cnt_nxt = hi_cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (ready) state_nxt = meas_en ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign valid = (state == HOLD);
  assign busy  = (state == ARM) || (state == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: 16-bit and 8-bit instances share stimulus,
// expected results are queued per instance and compared when valid appears.
module tb_period_meter;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        meas_en = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] period16, high16;
  logic        timeout16, valid16, busy16;
  logic [7:0]  period8, high8;
  logic        timeout8, valid8, busy8;

  int   passed = 0;
  int   total = 0;
  exp_t q16[$];
  exp_t q8[$];

  logic sq_on = 1'b0;
  logic sq_level = 1'b0;
  int   sq_p = 25;
  int   sq_h = 10;
  int   sq_gen = 0;

  period_meter #(.CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en), .ready(ready),
    .period(period16), .high_time(high16), .timeout(timeout16), .valid(valid16), .busy(busy16)
  );

  period_meter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en), .ready(ready),
    .period(period8), .high_time(high8), .timeout(timeout8), .valid(valid8), .busy(busy8)
  );

  always #5 clk = ~clk;

  // square-wave source; phase restarts whenever the main sequence bumps sq_gen
  initial begin
    int phase;
    int seen_gen;
    phase = 0;
    seen_gen = 0;
    forever begin
      @(negedge clk);
      if (sq_gen != seen_gen) begin
        seen_gen = sq_gen;
        phase = 0;
      end
      if (sq_on) begin
        sig_in = (phase < sq_h);
        phase = (phase + 1 == sq_p) ? 0 : phase + 1;
      end else begin
        sig_in = sq_level;
        phase = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wave(input int p, input int h);
    sq_p = p;
    sq_h = h;
    sq_gen++;
    sq_on = 1'b1;
  endtask

  // waits for valid on the chosen instance, then pops and compares one result
  task automatic wait_result(input bit sel8, input string tag, input int budget,
                             output int waited);
    logic        got;
    exp_t        e;
    logic [15:0] p, h;
    logic        t;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      got = sel8 ? valid8 : valid16;
    end
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    if (sel8) begin
      p = {8'd0, period8};
      h = {8'd0, high8};
      t = timeout8;
      e = (q8.size() > 0) ? q8.pop_front() : '0;
    end else begin
      p = period16;
      h = high16;
      t = timeout16;
      e = (q16.size() > 0) ? q16.pop_front() : '0;
    end
    check({tag, "_period"}, {16'd0, p}, {16'd0, e.p});
    check({tag, "_high"}, {16'd0, h}, {16'd0, e.h});
    check({tag, "_timeout"}, {31'd0, t}, {31'd0, e.t});
  endtask

  initial begin
    int   w;
    logic stable;
    logic none;

    // reset state
    cycles(2);
    check("rst_valid", {31'd0, valid16}, 32'd0);
    check("rst_busy", {31'd0, busy16}, 32'd0);
    check("rst_period", {16'd0, period16}, 32'd0);
    check("rst_high", {16'd0, high16}, 32'd0);
    check("rst_timeout", {31'd0, timeout16}, 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // continuous 25/10 wave with ready high
    ready = 1'b1;
    meas_en = 1'b1;
    wave(25, 10);
    for (int i = 0; i < 3; i++) begin
      q16.push_back('{p: 16'd25, h: 16'd10, t: 1'b0});
      wait_result(1'b0, "sq25", 120, w);
      @(negedge clk);
      check("sq25_one_cycle", {31'd0, valid16}, 32'd0);
    end

    // consumer stalls for 40 cycles while sig_in keeps toggling
    ready = 1'b0;
    q16.push_back('{p: 16'd25, h: 16'd10, t: 1'b0});
    wait_result(1'b0, "stall", 120, w);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(valid16 === 1'b1 && period16 === 16'd25 && high16 === 16'd10 && timeout16 === 1'b0))
        stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("stall_accept_valid", {31'd0, valid16}, 32'd0);
    check("stall_accept_busy", {31'd0, busy16}, 32'd1);

    // drain, then reset in the middle of a measurement
    ready = 1'b1;
    meas_en = 1'b0;
    cycles(3);
    meas_en = 1'b1;
    q16.push_back('{p: 16'd25, h: 16'd10, t: 1'b0});
    wait_result(1'b0, "pre_rst", 120, w);
    cycles(30);
    check("pre_rst_busy", {31'd0, busy16}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, valid16}, 32'd0);
    check("rst_mid_busy", {31'd0, busy16}, 32'd0);
    check("rst_mid_period", {16'd0, period16}, 32'd0);
    check("rst_mid_high", {16'd0, high16}, 32'd0);
    check("rst_mid_timeout", {31'd0, timeout16}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    q16.push_back('{p: 16'd25, h: 16'd10, t: 1'b0});
    wait_result(1'b0, "post_rst", 120, w);
    check("post_rst_two_rises", {31'd0, w >= 25}, 32'd1);

    // meas_en dropped mid-measurement, then re-enabled on a new wave
    q16.push_back('{p: 16'd25, h: 16'd10, t: 1'b0});
    wait_result(1'b0, "pre_drop", 120, w);
    cycles(30);
    check("pre_drop_busy", {31'd0, busy16}, 32'd1);
    meas_en = 1'b0;
    @(negedge clk);
    check("drop_busy", {31'd0, busy16}, 32'd0);
    check("drop_valid", {31'd0, valid16}, 32'd0);
    none = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid16 !== 1'b0) none = 1'b0;
    end
    check("drop_no_valid", {31'd0, none}, 32'd1);
    wave(30, 12);
    meas_en = 1'b1;
    q16.push_back('{p: 16'd30, h: 16'd12, t: 1'b0});
    wait_result(1'b0, "reenable", 150, w);

    // 8-bit: one rise then held high saturates
    sq_on = 1'b0;
    sq_level = 1'b0;
    meas_en = 1'b0;
    cycles(4);
    meas_en = 1'b1;
    cycles(3);
    sq_level = 1'b1;
    q8.push_back('{p: 16'd255, h: 16'd255, t: 1'b1});
    wait_result(1'b1, "sat8", 400, w);
    @(negedge clk);
    check("sat8_one_cycle", {31'd0, valid8}, 32'd0);

    // 8-bit: second rise lands on the saturating cycle
    sq_level = 1'b0;
    meas_en = 1'b0;
    cycles(4);
    wave(255, 100);
    meas_en = 1'b1;
    q8.push_back('{p: 16'd255, h: 16'd100, t: 1'b0});
    wait_result(1'b1, "edge_sat8", 800, w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
